// File: rtl/ddr3_axi_slave_mem.sv
// AXI4 slave memory model standing in for the DDR3 controller port.
// Ports: ACLK/ARESET, AXI4 AW/W/B write channels, AR/R read channels.
module ddr3_axi_slave_mem #(
  parameter int C_S_AXI_ID_WIDTH   = 1,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 32,
  parameter logic [C_S_AXI_ADDR_WIDTH-1:0] C_BASE_ADDR = 32'h4000_0000,
  parameter int C_MEM_DEPTH        = 1024
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [7:0]                      S_AXI_AWLEN,
  input  logic [2:0]                      S_AXI_AWSIZE,
  input  logic [1:0]                      S_AXI_AWBURST,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WLAST,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_BID,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [7:0]                      S_AXI_ARLEN,
  input  logic [2:0]                      S_AXI_ARSIZE,
  input  logic [1:0]                      S_AXI_ARBURST,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     S_AXI_RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RLAST,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY
);

  localparam int DW  = C_S_AXI_DATA_WIDTH;
  localparam int AW  = C_S_AXI_ADDR_WIDTH;
  localparam int NB  = DW / 8;
  localparam int ASZ = $clog2(NB);
  localparam int IW  = $clog2(C_MEM_DEPTH);

  localparam logic [AW:0] DEPTH_W = (AW+1)'(C_MEM_DEPTH);

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;
  localparam logic [1:0] INCR   = 2'b01;

  typedef enum logic [1:0] {
    W_IDLE, W_DATA, W_RESP
  } wstate_t;

  typedef enum logic {
    R_IDLE, R_DATA
  } rstate_t;

  // Range check covers the whole burst up front, so the
  // word index never wraps inside the array.
  function automatic logic [1:0] classify(
    input logic [AW-1:0] addr,
    input logic [7:0]    len,
    input logic [2:0]    size,
    input logic [1:0]    burst
  );
    logic [AW-1:0] off;
    logic [AW:0]   last;
    off  = addr - C_BASE_ADDR;
    last = {1'b0, off >> ASZ} + {{(AW-7){1'b0}}, len};
    if (addr < C_BASE_ADDR || last >= DEPTH_W)
      classify = DECERR;
    else if (burst[1] || size != 3'(ASZ))
      classify = SLVERR;
    else
      classify = OKAY;
  endfunction

  function automatic logic [IW-1:0] word_of(
    input logic [AW-1:0] addr
  );
    word_of = IW'((addr - C_BASE_ADDR) >> ASZ);
  endfunction

  logic [DW-1:0] mem [C_MEM_DEPTH];

  // ---------------- write side ----------------
  wstate_t       w_state, w_state_n;
  logic [IW-1:0] w_idx;
  logic [7:0]    w_len;
  logic [7:0]    w_beat;
  logic          w_incr;
  logic [1:0]    w_err;
  logic          w_lerr;
  logic          awready_d, wready_d, bvalid_d;

  logic aw_hs, w_hs, b_hs, w_last_beat;

  assign aw_hs = S_AXI_AWVALID & S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID & S_AXI_WREADY;
  assign b_hs  = S_AXI_BVALID & S_AXI_BREADY;
  assign w_last_beat = (w_beat == w_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) w_state <= W_IDLE;
    else        w_state <= w_state_n;
  end

  always_comb begin
    w_state_n = w_state;
    unique case (w_state)
      W_IDLE: if (aw_hs) w_state_n = W_DATA;
      W_DATA: if (w_hs && w_last_beat) w_state_n = W_RESP;
      W_RESP: if (b_hs) w_state_n = W_IDLE;
      default: w_state_n = W_IDLE;
    endcase
  end

  // Handshake outputs are registered copies of the next state,
  // so they stay low through reset and rise one edge after it.
  always_comb begin
    awready_d = (w_state_n == W_IDLE);
    wready_d  = (w_state_n == W_DATA);
    bvalid_d  = (w_state_n == W_RESP);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      S_AXI_BID     <= '0;
      S_AXI_BRESP   <= OKAY;
      w_idx         <= '0;
      w_len         <= '0;
      w_beat        <= '0;
      w_incr        <= 1'b0;
      w_err         <= OKAY;
      w_lerr        <= 1'b0;
    end else begin
      S_AXI_AWREADY <= awready_d;
      S_AXI_WREADY  <= wready_d;
      S_AXI_BVALID  <= bvalid_d;
      if (aw_hs) begin
        S_AXI_BID <= S_AXI_AWID;
        w_idx     <= word_of(S_AXI_AWADDR);
        w_len     <= S_AXI_AWLEN;
        w_beat    <= '0;
        w_incr    <= (S_AXI_AWBURST == INCR);
        w_err     <= classify(S_AXI_AWADDR, S_AXI_AWLEN,
                              S_AXI_AWSIZE, S_AXI_AWBURST);
        w_lerr    <= 1'b0;
      end
      if (w_hs) begin
        w_beat <= w_beat + 8'd1;
        if (w_incr) w_idx <= w_idx + IW'(1);
        if (!w_last_beat && S_AXI_WLAST) w_lerr <= 1'b1;
        // The beat count, not WLAST, closes the burst; a
        // misplaced WLAST only downgrades the response.
        if (w_last_beat) begin
          if (w_err != OKAY)
            S_AXI_BRESP <= w_err;
          else if (w_lerr || !S_AXI_WLAST)
            S_AXI_BRESP <= SLVERR;
          else
            S_AXI_BRESP <= OKAY;
        end
      end
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESET && w_hs && w_err == OKAY) begin
      for (int b = 0; b < NB; b++) begin
        if (S_AXI_WSTRB[b])
          mem[w_idx][8*b +: 8] <= S_AXI_WDATA[8*b +: 8];
      end
    end
  end

  // ---------------- read side ----------------
  rstate_t       r_state, r_state_n;
  logic [IW-1:0] r_next;
  logic [7:0]    r_len;
  logic [7:0]    r_beat;
  logic          r_incr;
  logic [1:0]    r_err;
  logic          arready_d, rvalid_d;

  logic          ar_hs, r_hs, r_last_beat;
  logic [1:0]    ar_err;
  logic [IW-1:0] ar_word;
  logic [IW-1:0] rd_word;
  logic [DW-1:0] rd_data;

  assign ar_hs = S_AXI_ARVALID & S_AXI_ARREADY;
  assign r_hs  = S_AXI_RVALID & S_AXI_RREADY;
  assign r_last_beat = (r_beat == r_len);
  assign ar_err = classify(S_AXI_ARADDR, S_AXI_ARLEN,
                           S_AXI_ARSIZE, S_AXI_ARBURST);
  assign ar_word = word_of(S_AXI_ARADDR);

  // One read port: the first beat comes from the AR address,
  // later beats from the precomputed next index.
  assign rd_word = (r_state == R_IDLE) ? ar_word : r_next;
  assign rd_data = mem[rd_word];

  always_ff @(posedge ACLK) begin
    if (ARESET) r_state <= R_IDLE;
    else        r_state <= r_state_n;
  end

  always_comb begin
    r_state_n = r_state;
    unique case (r_state)
      R_IDLE: if (ar_hs) r_state_n = R_DATA;
      R_DATA: if (r_hs && r_last_beat) r_state_n = R_IDLE;
      default: r_state_n = R_IDLE;
    endcase
  end

  always_comb begin
    arready_d = (r_state_n == R_IDLE);
    rvalid_d  = (r_state_n == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RID     <= '0;
      S_AXI_RDATA   <= '0;
      S_AXI_RRESP   <= OKAY;
      S_AXI_RLAST   <= 1'b0;
      r_next        <= '0;
      r_len         <= '0;
      r_beat        <= '0;
      r_incr        <= 1'b0;
      r_err         <= OKAY;
    end else begin
      S_AXI_ARREADY <= arready_d;
      S_AXI_RVALID  <= rvalid_d;
      if (ar_hs) begin
        S_AXI_RID   <= S_AXI_ARID;
        S_AXI_RRESP <= ar_err;
        S_AXI_RDATA <= (ar_err == OKAY) ? rd_data : '0;
        S_AXI_RLAST <= (S_AXI_ARLEN == 8'd0);
        r_len       <= S_AXI_ARLEN;
        r_beat      <= '0;
        r_incr      <= (S_AXI_ARBURST == INCR);
        r_err       <= ar_err;
        r_next      <= (S_AXI_ARBURST == INCR) ?
                       ar_word + IW'(1) : ar_word;
      end else if (r_hs) begin
        if (r_last_beat) begin
          S_AXI_RLAST <= 1'b0;
        end else begin
          r_beat      <= r_beat + 8'd1;
          S_AXI_RDATA <= (r_err == OKAY) ? rd_data : '0;
          S_AXI_RLAST <= ((r_beat + 8'd1) == r_len);
          if (r_incr) r_next <= r_next + IW'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_ddr3_axi_slave_mem.sv
// Scoreboard bench for ddr3_axi_slave_mem: directed bursts,
// expected B/R responses queued and checked by a monitor.
module tb_ddr3_axi_slave_mem;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [0:0]  AWID = '0;
  logic [31:0] AWADDR = '0;
  logic [7:0]  AWLEN = '0;
  logic [2:0]  AWSIZE = '0;
  logic [1:0]  AWBURST = '0;
  logic        AWVALID = 1'b0;
  logic        AWREADY;
  logic [31:0] WDATA = '0;
  logic [3:0]  WSTRB = '0;
  logic        WLAST = 1'b0;
  logic        WVALID = 1'b0;
  logic        WREADY;
  logic [0:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY = 1'b1;
  logic [0:0]  ARID = '0;
  logic [31:0] ARADDR = '0;
  logic [7:0]  ARLEN = '0;
  logic [2:0]  ARSIZE = '0;
  logic [1:0]  ARBURST = '0;
  logic        ARVALID = 1'b0;
  logic        ARREADY;
  logic [0:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY = 1'b1;

  ddr3_axi_slave_mem dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWID(AWID), .S_AXI_AWADDR(AWADDR),
    .S_AXI_AWLEN(AWLEN), .S_AXI_AWSIZE(AWSIZE),
    .S_AXI_AWBURST(AWBURST), .S_AXI_AWVALID(AWVALID),
    .S_AXI_AWREADY(AWREADY),
    .S_AXI_WDATA(WDATA), .S_AXI_WSTRB(WSTRB),
    .S_AXI_WLAST(WLAST), .S_AXI_WVALID(WVALID),
    .S_AXI_WREADY(WREADY),
    .S_AXI_BID(BID), .S_AXI_BRESP(BRESP),
    .S_AXI_BVALID(BVALID), .S_AXI_BREADY(BREADY),
    .S_AXI_ARID(ARID), .S_AXI_ARADDR(ARADDR),
    .S_AXI_ARLEN(ARLEN), .S_AXI_ARSIZE(ARSIZE),
    .S_AXI_ARBURST(ARBURST), .S_AXI_ARVALID(ARVALID),
    .S_AXI_ARREADY(ARREADY),
    .S_AXI_RID(RID), .S_AXI_RDATA(RDATA),
    .S_AXI_RRESP(RRESP), .S_AXI_RLAST(RLAST),
    .S_AXI_RVALID(RVALID), .S_AXI_RREADY(RREADY)
  );

  initial forever #5 ACLK = ~ACLK;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [2:0]  bq[$];
  logic [31:0] wd[$];
  logic [31:0] rd_exp[$];
  int          rr_mode = 0;
  int          asserts = 0;
  int          fails = 0;
  rbeat_t      mb;
  logic [2:0]  me;

  localparam logic [1:0] FIX = 2'b00;
  localparam logic [1:0] INC = 2'b01;
  localparam logic [1:0] WRP = 2'b10;

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    asserts++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RREADY pattern: 0 = always high, 1 = toggle, 2 = held low
  initial forever begin
    @(posedge ACLK);
    #1;
    case (rr_mode)
      0: RREADY = 1'b1;
      1: RREADY = ~RREADY;
      default: RREADY = 1'b0;
    endcase
  end

  // Monitor: a handshake seen at negedge completes at next posedge
  initial forever begin
    @(negedge ACLK);
    if (!ARESET) begin
      if (BVALID && BREADY) begin
        if (bq.size() == 0) chk("b_unexpected", BVALID, 0);
        else begin
          me = bq.pop_front();
          chk("b_resp", {BID, BRESP}, me);
        end
      end
      if (RVALID && rq.size() != 0) begin
        if (RREADY) begin
          mb = rq.pop_front();
          chk("r_beat", {RID, RRESP, RLAST, RDATA},
              {mb.id, mb.resp, mb.last, mb.data});
        end else begin
          chk("r_stall_data", RDATA, rq[0].data);
        end
      end else if (RVALID && RREADY) begin
        chk("r_unexpected", RVALID, 0);
      end
    end
  end

  task automatic wr(input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size,
                    input logic id, input logic [3:0] strb,
                    input int last_at, input logic [1:0] resp);
    int n;
    bq.push_back({id, resp});
    AWADDR = addr; AWLEN = len; AWBURST = burst;
    AWSIZE = size; AWID = id; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) chk("aw_timeout", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      WDATA = wd[i]; WSTRB = strb;
      WLAST = (i == last_at); WVALID = 1'b1;
      n = 0;
      while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
      if (!WREADY) chk("w_timeout", WREADY, 1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0;
    @(negedge ACLK);
    chk("b_latency", BVALID, 1);
    n = 0;
    while (bq.size() != 0 && n < 50) begin @(negedge ACLK); n++; end
    if (bq.size() != 0) chk("b_timeout", bq.size(), 0);
    @(posedge ACLK); #1;
  endtask

  task automatic rd(input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [2:0] size,
                    input logic id, input logic [1:0] resp);
    int n;
    rbeat_t b;
    for (int i = 0; i <= int'(len); i++) begin
      b.id = id; b.resp = resp; b.last = (i == int'(len));
      if (resp != 2'b00) b.data = '0;
      else b.data = rd_exp[i];
      rq.push_back(b);
    end
    ARADDR = addr; ARLEN = len; ARBURST = burst;
    ARSIZE = size; ARID = id; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) chk("ar_timeout", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("r_latency", RVALID, 1);
    n = 0;
    while (rq.size() != 0 && n < 200) begin @(negedge ACLK); n++; end
    if (rq.size() != 0) begin
      chk("r_timeout", rq.size(), 0);
      rq.delete();
    end
    @(posedge ACLK); #1;
  endtask

  task automatic pulse_reset(input string tag);
    ARESET = 1'b1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({tag, "_outs_low"},
        {AWREADY, WREADY, BVALID, ARREADY, RVALID}, 0);
    ARESET = 1'b0;
    @(posedge ACLK);
    @(negedge ACLK);
    chk({tag, "_ready"}, {AWREADY, ARREADY}, 2'b11);
    @(posedge ACLK); #1;
  endtask

  initial begin
    int n;
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("reset_outs",
        {AWREADY, WREADY, BVALID, BID, BRESP, ARREADY,
         RVALID, RDATA, RRESP, RLAST, RID}, 0);
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    @(negedge ACLK);
    chk("ready_at_release", {AWREADY, ARREADY}, 2'b00);
    @(negedge ACLK);
    chk("ready_after_release", {AWREADY, ARREADY}, 2'b11);
    @(posedge ACLK); #1;

    // basic INCR burst
    wd = '{32'd1, 32'd2, 32'd3, 32'd4};
    wr(32'h4000_0000, 3, INC, 2, 1, 4'hF, 3, 2'b00);
    rd_exp = '{32'd1, 32'd2, 32'd3, 32'd4};
    rd(32'h4000_0000, 3, INC, 2, 0, 2'b00);

    // byte strobes
    wd = '{32'hAABB_CCDD};
    wr(32'h4000_0010, 0, INC, 2, 0, 4'hF, 0, 2'b00);
    wd = '{32'h1122_3344};
    wr(32'h4000_0010, 0, INC, 2, 1, 4'b0101, 0, 2'b00);
    rd_exp = '{32'hAA22_CC44};
    rd(32'h4000_0010, 0, INC, 2, 1, 2'b00);

    // top-of-array boundary and decode errors
    wd = '{32'hDEAD_BEEF};
    wr(32'h4000_0FFC, 0, INC, 2, 0, 4'hF, 0, 2'b00);
    wd = '{32'd1, 32'd2};
    wr(32'h4000_0FFC, 1, INC, 2, 0, 4'hF, 1, 2'b11);
    rd(32'h4000_0FFC, 1, INC, 2, 0, 2'b11);
    rd_exp = '{32'hDEAD_BEEF};
    rd(32'h4000_0FFC, 0, INC, 2, 0, 2'b00);
    rd(32'h3FFF_FFFC, 0, INC, 2, 1, 2'b11);
    wd = '{32'd0};
    wr(32'h4000_1000, 0, WRP, 2, 0, 4'hF, 0, 2'b11);

    // slave errors: wrap burst, bad size (no write)
    rd(32'h4000_0000, 3, WRP, 2, 0, 2'b10);
    wd = '{32'd0};
    wr(32'h4000_0010, 0, INC, 1, 0, 4'hF, 0, 2'b10);
    rd_exp = '{32'hAA22_CC44};
    rd(32'h4000_0010, 0, INC, 2, 0, 2'b00);

    // FIXED burst hits one word
    wd = '{32'd7, 32'd8, 32'd9};
    wr(32'h4000_0050, 2, FIX, 2, 1, 4'hF, 2, 2'b00);
    rd_exp = '{32'd9, 32'd9};
    rd(32'h4000_0050, 1, FIX, 2, 1, 2'b00);

    // early WLAST: all beats still written, SLVERR
    wd = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    wr(32'h4000_0080, 3, INC, 2, 0, 4'hF, 1, 2'b10);
    rd_exp = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    rd(32'h4000_0080, 3, INC, 2, 0, 2'b00);
    // missing WLAST
    wd = '{32'hB0, 32'hB1};
    wr(32'h4000_0090, 1, INC, 2, 1, 4'hF, 5, 2'b10);

    // LEN=7 read with RREADY toggling
    wd = '{32'h100, 32'h101, 32'h102, 32'h103,
           32'h104, 32'h105, 32'h106, 32'h107};
    wr(32'h4000_00A0, 7, INC, 2, 0, 4'hF, 7, 2'b00);
    rr_mode = 1;
    rd_exp = wd;
    rd(32'h4000_00A0, 7, INC, 2, 1, 2'b00);
    rr_mode = 0;
    @(posedge ACLK); #1;

    // reset in the middle of a write burst
    AWADDR = 32'h4000_00C0; AWLEN = 3; AWBURST = INC;
    AWSIZE = 2; AWID = 0; AWVALID = 1'b1;
    n = 0;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!AWREADY) chk("aw_timeout", AWREADY, 1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    WDATA = 32'hDEAD_0001; WSTRB = 4'hF; WLAST = 1'b0;
    WVALID = 1'b1;
    @(posedge ACLK); #1;
    pulse_reset("rst_w");

    // reset in the middle of a read burst
    rr_mode = 2;
    @(posedge ACLK); #1;
    ARADDR = 32'h4000_00A0; ARLEN = 7; ARBURST = INC;
    ARSIZE = 2; ARID = 1; ARVALID = 1'b1;
    n = 0;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    if (!ARREADY) chk("ar_timeout", ARREADY, 1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    @(negedge ACLK);
    chk("r_stalled_first", {RVALID, RDATA}, {1'b1, 32'h100});
    @(posedge ACLK); #1;
    pulse_reset("rst_r");
    rr_mode = 0;
    @(posedge ACLK); #1;

    // contents survive the resets
    rd_exp = '{32'd1, 32'd2, 32'd3, 32'd4};
    rd(32'h4000_0000, 3, INC, 2, 0, 2'b00);
    rd_exp = '{32'h100, 32'h101, 32'h102, 32'h103,
               32'h104, 32'h105, 32'h106, 32'h107};
    rd(32'h4000_00A0, 7, INC, 2, 1, 2'b00);

    repeat (3) @(posedge ACLK);
    $display("End of test - %0d assertions evaluated, %0d failures",
             asserts, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
